// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-LED pattern generator with four patterns, pause, PWM dimming and a step strobe.
module led_pattern_gen #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int NUM_LEDS    = 4,
  parameter int STEP_CYCLES = CLOCK_FREQ / 2,
  parameter int PWM_BITS    = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic [1:0]          MODE,
  input  logic [PWM_BITS-1:0] BRIGHT,
  output logic [NUM_LEDS-1:0] LED,
  output logic                STEP
);
  localparam int CW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0] ONE = NUM_LEDS'(1);
  typedef enum logic [1:0] {ROT_L, ROT_R, PING, BLINK} mode_e;
  mode_e                mode_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_LEDS-1:0]  pat_q, pat_d, rotl, rotr, ping, step_pat, led_d;
  logic [PWM_BITS-1:0]  pwm_q;
  logic                 up_q, up_d, step_d, mode_chg, wrap, pwm_on;
  always_comb begin
    mode_chg = MODE != mode_q;
    wrap     = EN && cnt_q == LAST;
    rotl     = (pat_q << 1) | (pat_q >> (NUM_LEDS - 1));
    rotr     = (pat_q >> 1) | (pat_q << (NUM_LEDS - 1));
    // never shift the lit bit off the end; only a one-LED build ever holds here
    ping     = pat_q[up_q ? NUM_LEDS - 1 : 0] ? pat_q : up_q ? pat_q << 1 : pat_q >> 1;
    step_pat = mode_q == ROT_L ? rotl : mode_q == ROT_R ? rotr : mode_q == PING ? ping : ~pat_q;
    cnt_d    = mode_chg ? '0 : !EN ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
    pat_d    = mode_chg ? (MODE == BLINK ? '0 : ONE) : wrap ? step_pat : pat_q;
    up_d     = mode_chg ? 1'b1 : (wrap && mode_q == PING) ? (up_q ? !ping[NUM_LEDS-1] : ping[0]) : up_q;
    step_d   = wrap && !mode_chg;
    pwm_on   = &BRIGHT || pwm_q < BRIGHT;
    led_d    = pat_d & {NUM_LEDS{pwm_on}};
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q <= ROT_L;
      cnt_q  <= '0;
      pat_q  <= ONE;
      up_q   <= 1'b1;
      pwm_q  <= '0;
      LED    <= '0;
      STEP   <= 1'b0;
    end else begin
      mode_q <= mode_e'(MODE);
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
      up_q   <= up_d;
      pwm_q  <= pwm_q + 1'b1;
      LED    <= led_d;
      STEP   <= step_d;
    end
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen (4-LED build plus a 1-LED build on shared inputs).
module tb_led_pattern_gen;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       EN = 1'b0;
  logic [1:0] MODE = 2'd0;
  logic [3:0] BRIGHT = 4'd0;
  logic [3:0] led;
  logic       step;
  logic       led1;
  logic       step1;
  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [3:0] bright;
    logic [3:0] led;
    logic       step;
    logic       led1;
  } ent_t;
  ent_t q[$];
  int passed = 0;
  int total = 0;
  int edges = 0;
  always #5 CLK = ~CLK;
  led_pattern_gen #(.CLOCK_FREQ(50000000), .NUM_LEDS(4), .STEP_CYCLES(4), .PWM_BITS(4)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .BRIGHT(BRIGHT), .LED(led), .STEP(step));
  led_pattern_gen #(.CLOCK_FREQ(50000000), .NUM_LEDS(1), .STEP_CYCLES(4), .PWM_BITS(4)) u_one (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .BRIGHT(BRIGHT), .LED(led1), .STEP(step1));
  task automatic push(input logic en, input logic [1:0] mode, input logic [3:0] bright,
                      input logic [3:0] l, input logic s, input logic l1);
    ent_t e;
    e.en = en; e.mode = mode; e.bright = bright; e.led = l; e.step = s; e.led1 = l1;
    q.push_back(e);
  endtask
  // three quiet cycles holding prev, then the step edge showing nxt
  task automatic push_step(input logic [1:0] mode, input logic [3:0] prev, input logic [3:0] nxt,
                           input logic p1, input logic n1);
    for (int i = 0; i < 3; i++) push(1'b1, mode, 4'd15, prev, 1'b0, p1);
    push(1'b1, mode, 4'd15, nxt, 1'b1, n1);
  endtask
  task automatic test_reset;
    ent_t e;
    RST_N = 1'b0; EN = 1'b1; MODE = 2'd0; BRIGHT = 4'd15;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (led !== 4'b0000) $display("FAIL reset led: got %b want 0000", led); else passed++;
    total++; if (step !== 1'b0) $display("FAIL reset step: got %b want 0", step); else passed++;
    total++; if (led1 !== 1'b0) $display("FAIL reset led1: got %b want 0", led1); else passed++;
    RST_N = 1'b1;
    edges = 0;
    push_step(2'd0, 4'b0001, 4'b0010, 1'b1, 1'b1);
    push_step(2'd0, 4'b0010, 4'b0100, 1'b1, 1'b1);
    push_step(2'd0, 4'b0100, 4'b1000, 1'b1, 1'b1);
    push_step(2'd0, 4'b1000, 4'b0001, 1'b1, 1'b1);
    while (q.size() > 0) begin
      e = q.pop_front();
      EN = e.en; MODE = e.mode; BRIGHT = e.bright;
      @(posedge CLK); #1; edges++;
      total++; if (led !== e.led) $display("FAIL rotl led: got %b want %b", led, e.led); else passed++;
      total++; if (step !== e.step) $display("FAIL rotl step: got %b want %b", step, e.step); else passed++;
      total++; if (led1 !== e.led1) $display("FAIL rotl led1: got %b want %b", led1, e.led1); else passed++;
    end
  endtask
  task automatic test_pingpong;
    ent_t e;
    logic [3:0] seq [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    logic [3:0] prev = 4'b0001;
    push(1'b1, 2'd2, 4'd15, 4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      push_step(2'd2, prev, seq[i], 1'b1, 1'b1);
      prev = seq[i];
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      EN = e.en; MODE = e.mode; BRIGHT = e.bright;
      @(posedge CLK); #1; edges++;
      total++; if (led !== e.led) $display("FAIL ping led: got %b want %b", led, e.led); else passed++;
      total++; if (step !== e.step) $display("FAIL ping step: got %b want %b", step, e.step); else passed++;
      total++; if (led1 !== e.led1) $display("FAIL ping led1: got %b want %b", led1, e.led1); else passed++;
    end
  endtask
  task automatic test_blink_switch;
    ent_t e;
    push(1'b1, 2'd3, 4'd15, 4'b0000, 1'b0, 1'b0);
    push_step(2'd3, 4'b0000, 4'b1111, 1'b0, 1'b1);
    push_step(2'd3, 4'b1111, 4'b0000, 1'b1, 1'b0);
    push_step(2'd3, 4'b0000, 4'b1111, 1'b0, 1'b1);
    push(1'b1, 2'd3, 4'd15, 4'b1111, 1'b0, 1'b1);
    push(1'b1, 2'd3, 4'd15, 4'b1111, 1'b0, 1'b1);
    push(1'b1, 2'd1, 4'd15, 4'b0001, 1'b0, 1'b1);
    push_step(2'd1, 4'b0001, 4'b1000, 1'b1, 1'b1);
    push_step(2'd1, 4'b1000, 4'b0100, 1'b1, 1'b1);
    // mode change landing on the wrap cycle: reload wins, no strobe
    for (int i = 0; i < 3; i++) push(1'b1, 2'd1, 4'd15, 4'b0100, 1'b0, 1'b1);
    push(1'b1, 2'd0, 4'd15, 4'b0001, 1'b0, 1'b1);
    while (q.size() > 0) begin
      e = q.pop_front();
      EN = e.en; MODE = e.mode; BRIGHT = e.bright;
      @(posedge CLK); #1; edges++;
      total++; if (led !== e.led) $display("FAIL blink/switch led: got %b want %b", led, e.led); else passed++;
      total++; if (step !== e.step) $display("FAIL blink/switch step: got %b want %b", step, e.step); else passed++;
      total++; if (led1 !== e.led1) $display("FAIL blink/switch led1: got %b want %b", led1, e.led1); else passed++;
    end
  endtask
  task automatic test_pause;
    ent_t e;
    push_step(2'd0, 4'b0001, 4'b0010, 1'b1, 1'b1);
    push_step(2'd0, 4'b0010, 4'b0100, 1'b1, 1'b1);
    push(1'b1, 2'd0, 4'd15, 4'b0100, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) push(1'b0, 2'd0, 4'd15, 4'b0100, 1'b0, 1'b1);
    push(1'b1, 2'd0, 4'd15, 4'b0100, 1'b0, 1'b1);
    push(1'b1, 2'd0, 4'd15, 4'b0100, 1'b0, 1'b1);
    push(1'b1, 2'd0, 4'd15, 4'b1000, 1'b1, 1'b1);
    while (q.size() > 0) begin
      e = q.pop_front();
      EN = e.en; MODE = e.mode; BRIGHT = e.bright;
      @(posedge CLK); #1; edges++;
      total++; if (led !== e.led) $display("FAIL pause led: got %b want %b", led, e.led); else passed++;
      total++; if (step !== e.step) $display("FAIL pause step: got %b want %b", step, e.step); else passed++;
      total++; if (led1 !== e.led1) $display("FAIL pause led1: got %b want %b", led1, e.led1); else passed++;
    end
  endtask
  task automatic test_pwm;
    ent_t e;
    int p;
    for (int i = 0; i < 32; i++) begin
      p = (edges + q.size()) % 16;
      push(1'b0, 2'd0, 4'd4, p < 4 ? 4'b1000 : 4'b0000, 1'b0, p < 4);
    end
    for (int i = 0; i < 16; i++) push(1'b0, 2'd0, 4'd0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b0, 2'd0, 4'd15, 4'b1000, 1'b0, 1'b1);
    while (q.size() > 0) begin
      e = q.pop_front();
      EN = e.en; MODE = e.mode; BRIGHT = e.bright;
      @(posedge CLK); #1; edges++;
      total++; if (led !== e.led) $display("FAIL pwm led: got %b want %b", led, e.led); else passed++;
      total++; if (step !== e.step) $display("FAIL pwm step: got %b want %b", step, e.step); else passed++;
      total++; if (led1 !== e.led1) $display("FAIL pwm led1: got %b want %b", led1, e.led1); else passed++;
    end
  endtask
  task automatic test_async_reset;
    ent_t e;
    push(1'b1, 2'd2, 4'd15, 4'b0001, 1'b0, 1'b1);
    push_step(2'd2, 4'b0001, 4'b0010, 1'b1, 1'b1);
    while (q.size() > 0) begin
      e = q.pop_front();
      EN = e.en; MODE = e.mode; BRIGHT = e.bright;
      @(posedge CLK); #1; edges++;
      total++; if (led !== e.led) $display("FAIL pre-reset led: got %b want %b", led, e.led); else passed++;
      total++; if (step !== e.step) $display("FAIL pre-reset step: got %b want %b", step, e.step); else passed++;
      total++; if (led1 !== e.led1) $display("FAIL pre-reset led1: got %b want %b", led1, e.led1); else passed++;
    end
    #2 RST_N = 1'b0;
    #1;
    total++; if (led !== 4'b0000) $display("FAIL async reset led: got %b want 0000", led); else passed++;
    total++; if (step !== 1'b0) $display("FAIL async reset step: got %b want 0", step); else passed++;
    total++; if (led1 !== 1'b0) $display("FAIL async reset led1: got %b want 0", led1); else passed++;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    edges = 0;
    push(1'b1, 2'd2, 4'd15, 4'b0001, 1'b0, 1'b1);
    push_step(2'd2, 4'b0001, 4'b0010, 1'b1, 1'b1);
    push_step(2'd2, 4'b0010, 4'b0100, 1'b1, 1'b1);
    push_step(2'd2, 4'b0100, 4'b1000, 1'b1, 1'b1);
    push_step(2'd2, 4'b1000, 4'b0100, 1'b1, 1'b1);
    while (q.size() > 0) begin
      e = q.pop_front();
      EN = e.en; MODE = e.mode; BRIGHT = e.bright;
      @(posedge CLK); #1; edges++;
      total++; if (led !== e.led) $display("FAIL post-reset led: got %b want %b", led, e.led); else passed++;
      total++; if (step !== e.step) $display("FAIL post-reset step: got %b want %b", step, e.step); else passed++;
      total++; if (led1 !== e.led1) $display("FAIL post-reset led1: got %b want %b", led1, e.led1); else passed++;
    end
  endtask
  initial begin
    test_reset;
    test_pingpong;
    test_blink_switch;
    test_pause;
    test_pwm;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
